// File: rtl/ram_pkg.sv
// Shared definitions for the bidirectional-bus RAM: clear/idle state encoding
// and the byte-enable width derived from the data width.
package ram_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_core.sv
// Storage array with a byte-masked synchronous write port and a synchronous
// read register; one access per edge, arbitration is done by the caller.
module ram_core
    import ram_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 5,
    localparam int BE_WIDTH   = be_width(DATA_WIDTH),
    localparam int DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BE_WIDTH-1:0]   be,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rd_q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (re) begin
            rd_q <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_bidir_param.sv
// Single-port RAM on a shared tri-state bus: zeroes the array after reset, then
// serves 1-cycle reads and byte-masked writes; drives the bus only while rd_valid.
module ram_bidir_param
    import ram_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 5,
    localparam int BE_WIDTH   = be_width(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wena,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [BE_WIDTH-1:0]   be,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  wr_err
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_LAST = '1;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clr_ptr_q;
    logic                  busy_q;
    logic                  rd_valid_q;
    logic                  wr_err_q;

    logic                  clr_we;
    logic                  acc_rd;
    logic                  acc_wr;
    logic                  conflict;
    logic                  core_we;
    logic [ADDR_WIDTH-1:0] core_addr;
    logic [BE_WIDTH-1:0]   core_be;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] rd_q;

    // A write landing while we still drive the bus would sample our own read data.
    always_comb begin
        clr_we     = (state_q == CLEAR) && !rst;
        acc_rd     = (state_q == IDLE) && !rst && ena && !wena;
        acc_wr     = (state_q == IDLE) && !rst && ena && wena && !rd_valid_q;
        conflict   = (state_q == IDLE) && ena && wena && rd_valid_q;
        core_we    = clr_we || acc_wr;
        core_addr  = clr_we ? clr_ptr_q : addr;
        core_be    = clr_we ? '1 : be;
        core_wdata = clr_we ? '0 : data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clr_ptr_q  <= clr_ptr_q + PTR_ONE;
                    rd_valid_q <= 1'b0;
                    wr_err_q   <= 1'b0;
                    if (clr_ptr_q == PTR_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    rd_valid_q <= acc_rd;
                    wr_err_q   <= conflict;
                end
                default: begin
                    state_q <= CLEAR;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    ram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .we    (core_we),
        .re    (acc_rd),
        .addr  (core_addr),
        .be    (core_be),
        .wdata (core_wdata),
        .rd_q  (rd_q)
    );

    assign data     = rd_valid_q ? rd_q : {DATA_WIDTH{1'bz}};
    assign rd_valid = rd_valid_q;
    assign busy     = busy_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_ram_bidir_param.sv
// Directed bench for ram_bidir_param: clear sequence, reads, byte-masked writes,
// bus conflicts, idle bus and reset during clear, against hand-computed values.
module tb_ram_bidir_param;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        wena;
    logic [4:0]  addr;
    logic [3:0]  be;
    wire  [31:0] data;
    logic        rd_valid;
    logic        busy;
    logic        wr_err;

    logic        tb_oe;
    logic [31:0] tb_drv;

    int n_cmp = 0;
    int n_err = 0;

    assign data = tb_oe ? tb_drv : 32'hzzzz_zzzz;

    ram_bidir_param #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (5)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .wena     (wena),
        .addr     (addr),
        .be       (be),
        .data     (data),
        .rd_valid (rd_valid),
        .busy     (busy),
        .wr_err   (wr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_read(input logic [4:0] a, input logic [31:0] exp, input string tag);
        ena  = 1'b1;
        wena = 1'b0;
        addr = a;
        tick();
        chk({tag, "_vld"}, 32'(rd_valid), 32'd1);
        chk(tag, data, exp);
        ena = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        tb_drv = d;
        tb_oe  = 1'b1;
        ena    = 1'b1;
        wena   = 1'b1;
        addr   = a;
        be     = b;
        tick();
        ena   = 1'b0;
        wena  = 1'b0;
        tb_oe = 1'b0;
        tick();
    endtask

    // Counts edges until busy drops; optionally pokes the RAM while clearing.
    task automatic wait_clear(input bit poke, output int cnt, output bit saw_vld, output bit saw_err);
        cnt     = 0;
        saw_vld = 1'b0;
        saw_err = 1'b0;
        while (busy && cnt < 100) begin
            if (poke) begin
                ena    = 1'b1;
                wena   = cnt[0];
                addr   = cnt[0] ? 5'd0 : 5'(cnt);
                be     = 4'hF;
                tb_drv = 32'hDEAD_BEEF;
                tb_oe  = cnt[0];
            end
            tick();
            cnt++;
            if (rd_valid) saw_vld = 1'b1;
            if (wr_err)   saw_err = 1'b1;
        end
        ena   = 1'b0;
        wena  = 1'b0;
        tb_oe = 1'b0;
    endtask

    initial begin
        int cnt;
        bit saw_vld;
        bit saw_err;

        rst    = 1'b1;
        ena    = 1'b0;
        wena   = 1'b0;
        addr   = '0;
        be     = '0;
        tb_oe  = 1'b0;
        tb_drv = '0;

        tick();
        tick();
        chk("rst_busy",     32'(busy),     32'd1);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wr_err",   32'(wr_err),   32'd0);

        rst = 1'b0;
        wait_clear(1'b0, cnt, saw_vld, saw_err);
        chk("clear_len", 32'(cnt), 32'd32);

        do_read(5'd0,  32'h0, "clr_rd0");
        do_read(5'd15, 32'h0, "clr_rd15");
        do_read(5'd31, 32'h0, "clr_rd31");
        tick();
        chk("rd_pulse_end", 32'(rd_valid), 32'd0);

        do_write(5'd2, 32'h0000_0080, 4'hF);
        do_read(5'd2, 32'h0000_0080, "wr_rd2");
        tick();

        do_write(5'd5, 32'h1122_3344, 4'hF);
        do_write(5'd5, 32'hAABB_CCDD, 4'b0101);
        do_read(5'd5, 32'h11BB_33DD, "mask_rd5");
        tick();
        do_write(5'd5, 32'hFFFF_FFFF, 4'h0);
        do_read(5'd5, 32'h11BB_33DD, "be0_rd5");
        tick();

        do_read(5'd2, 32'h0000_0080, "conf_rd");
        tb_drv = 32'hFFFF_FFFF;
        tb_oe  = 1'b1;
        ena    = 1'b1;
        wena   = 1'b1;
        addr   = 5'd2;
        be     = 4'hF;
        tick();
        chk("conf_wr_err",   32'(wr_err),   32'd1);
        chk("conf_rd_valid", 32'(rd_valid), 32'd0);
        ena   = 1'b0;
        wena  = 1'b0;
        tb_oe = 1'b0;
        tick();
        chk("conf_err_end", 32'(wr_err), 32'd0);
        do_read(5'd2, 32'h0000_0080, "conf_reread");
        tick();

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_rd_valid", 32'(rd_valid), 32'd0);
        end
        tb_drv = 32'h1234_5678;
        tb_oe  = 1'b1;
        wena   = 1'b1;
        addr   = 5'd2;
        be     = 4'hF;
        tick();
        chk("idle_wena_vld", 32'(rd_valid), 32'd0);
        chk("idle_wena_err", 32'(wr_err),   32'd0);
        wena  = 1'b0;
        tb_oe = 1'b0;
        tick();
        do_read(5'd2, 32'h0000_0080, "idle_reread");
        tick();

        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("midclr_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("midclr_rst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        wait_clear(1'b1, cnt, saw_vld, saw_err);
        chk("midclr_len",     32'(cnt),     32'd32);
        chk("midclr_no_vld",  32'(saw_vld), 32'd0);
        chk("midclr_no_err",  32'(saw_err), 32'd0);
        do_read(5'd0, 32'h0, "midclr_rd0");
        do_read(5'd2, 32'h0, "midclr_rd2");
        do_read(5'd5, 32'h0, "midclr_rd5");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
